// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: sequences the enable pin of a shared clock gating buffer.
// The buffer is woken on demand, given a settle period, and then requesters
// receive per-bit grants. After an idle timeout the buffer is gated off.
// All outputs come directly from flops in the mclk domain.
//
// Optional build macro: CLK_GATE_STATS_EN adds a saturating gate-off counter
// output (gate_cnt). When the macro is undefined, that port and its logic are absent.
module clk_gate_ctrl #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WAKE_CYC = 4,
    parameter int unsigned IDLE_CYC = 8
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             force_on,
    output logic             gclk_en,
    output logic [N_REQ-1:0] ack,
    output logic [1:0]       state
`ifdef CLK_GATE_STATS_EN
    ,
    output logic [15:0]      gate_cnt
`endif
);

    // One counter is shared by WAKE and DRAIN, so it is sized for the longer period.
    localparam int unsigned MaxCyc = (WAKE_CYC > IDLE_CYC) ? WAKE_CYC : IDLE_CYC;
    localparam int unsigned CntW   = $clog2(MaxCyc) + 1;

    localparam logic [CntW-1:0] WakeLoad = CntW'(WAKE_CYC - 1);
    localparam logic [CntW-1:0] IdleLoad = CntW'(IDLE_CYC - 1);
    localparam logic [CntW-1:0] CntZero  = '0;
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [1:0] {
        StOff   = 2'd0,
        StWake  = 2'd1,
        StOn    = 2'd2,
        StDrain = 2'd3
    } state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic             gclk_en_q;
    logic [N_REQ-1:0] ack_q;

    logic any_req;
    logic cnt_zero;
    logic drain_exit;

    // Any requester, or the debug override, keeps the buffer wanted.
    assign any_req  = (|req) | force_on;
    assign cnt_zero = (cnt_q == CntZero);

    // This transition gates the buffer off. A request on this edge would win over the exit.
    assign drain_exit = (state_q == StDrain) && !any_req && cnt_zero;

    // Main sequencer: state, shared down-counter and registered outputs.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StOff;
            cnt_q     <= CntZero;
            gclk_en_q <= 1'b0;
            ack_q     <= '0;
        end else begin
            unique case (state_q)
                StOff: begin
                    ack_q <= '0;
                    if (any_req) begin
                        state_q   <= StWake;
                        gclk_en_q <= 1'b1;
                        cnt_q     <= WakeLoad;
                    end
                end
                StWake: begin
                    // WAKE is not aborted when requests drop. The ON state handles the drop.
                    ack_q <= '0;
                    if (cnt_zero) begin
                        state_q <= StOn;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
                StOn: begin
                    if (!any_req) begin
                        state_q <= StDrain;
                        cnt_q   <= IdleLoad;
                        ack_q   <= '0;
                    end else begin
                        ack_q <= req;
                    end
                end
                StDrain: begin
                    ack_q <= '0;
                    if (any_req) begin
                        // Leftover idle count is ignored. Acks resume one cycle after ON.
                        state_q <= StOn;
                    end else if (cnt_zero) begin
                        state_q   <= StOff;
                        gclk_en_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CntOne;
                    end
                end
            endcase
        end
    end

    assign gclk_en = gclk_en_q;
    assign ack     = ack_q;
    assign state   = state_q;

`ifdef CLK_GATE_STATS_EN
    logic [15:0] gate_cnt_q;

    // Count gate-off events, and hold the value at the top instead of wrapping.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt_q <= 16'h0000;
        end else if (drain_exit && (gate_cnt_q != 16'hFFFF)) begin
            gate_cnt_q <= gate_cnt_q + 16'h0001;
        end
    end

    assign gate_cnt = gate_cnt_q;
`else
    logic unused_drain_exit;
    assign unused_drain_exit = drain_exit;
`endif

    // The enable is high exactly when the sequencer is out of OFF.
    a_en_matches_state : assert property (
        @(posedge mclk) disable iff (!rst_n) gclk_en_q == (state_q != StOff)
    );

    // Grants are only ever visible while ON.
    a_ack_only_in_on : assert property (
        @(posedge mclk) disable iff (!rst_n) (ack_q != '0) |-> (state_q == StOn)
    );

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Testbench for clk_gate_ctrl: directed scenarios plus randomized traffic. The
// DUT is checked on every falling edge against a phase/elapsed-time reference model.
module tb_clk_gate_ctrl;

    localparam int N_REQ    = 4;
    localparam int WAKE_CYC = 4;
    localparam int IDLE_CYC = 8;

    logic             mclk = 1'b0;
    logic             rst_n;
    logic [N_REQ-1:0] req;
    logic             force_on;
    logic             gclk_en;
    logic [N_REQ-1:0] ack;
    logic [1:0]       state;
`ifdef CLK_GATE_STATS_EN
    logic [15:0]      gate_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    clk_gate_ctrl #(
        .N_REQ    (N_REQ),
        .WAKE_CYC (WAKE_CYC),
        .IDLE_CYC (IDLE_CYC)
    ) u_dut (
        .mclk     (mclk),
        .rst_n    (rst_n),
        .req      (req),
        .force_on (force_on),
        .gclk_en  (gclk_en),
        .ack      (ack),
        .state    (state)
`ifdef CLK_GATE_STATS_EN
        ,
        .gate_cnt (gate_cnt)
`endif
    );

    always #5 mclk = ~mclk;

    // Reference model. It tracks the phase name and the cycles spent in that phase.
    // Phases: 0 = off, 1 = waking, 2 = on, 3 = draining
    int               m_phase;
    int               m_elapsed;
    logic [N_REQ-1:0] m_ack;
    int               m_gates;

    function automatic void model_reset();
        m_phase   = 0;
        m_elapsed = 0;
        m_ack     = '0;
        m_gates   = 0;
    endfunction

    // Advance the model by one clock. It uses the inputs that were present at the clock edge.
    function automatic void model_step();
        bit want;
        want = (req != '0) || force_on;
        case (m_phase)
            0: begin
                m_ack = '0;
                if (want) begin
                    m_phase   = 1;
                    m_elapsed = 0;
                end
            end
            1: begin
                m_ack     = '0;
                m_elapsed = m_elapsed + 1;
                if (m_elapsed == WAKE_CYC) m_phase = 2;
            end
            2: begin
                if (want) begin
                    m_ack = req;
                end else begin
                    m_ack     = '0;
                    m_phase   = 3;
                    m_elapsed = 0;
                end
            end
            default: begin
                m_ack = '0;
                if (want) begin
                    m_phase = 2;
                end else begin
                    m_elapsed = m_elapsed + 1;
                    if (m_elapsed == IDLE_CYC) begin
                        m_phase = 0;
                        if (m_gates < 65535) m_gates = m_gates + 1;
                    end
                end
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("model_state", 32'(state), 32'(m_phase));
        check("model_gclk_en", 32'(gclk_en), (m_phase != 0) ? 32'd1 : 32'd0);
        check("model_ack", 32'(ack), 32'(m_ack));
`ifdef CLK_GATE_STATS_EN
        check("model_gate_cnt", 32'(gate_cnt), 32'(m_gates));
`endif
    endtask

    // One clock: the model steps at the edge, and the DUT is compared on the falling edge.
    task automatic tick();
        @(posedge mclk);
        model_step();
        @(negedge mclk);
        compare_all();
    endtask

    // Asynchronous reset pulse that occurs between clock edges. The DUT is checked before the next edge.
    task automatic async_reset(input string tag);
        @(negedge mclk);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_gclk_en"}, 32'(gclk_en), 32'd0);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        #1 rst_n = 1'b1;
    endtask

    int mode;

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        force_on = 1'b0;
        model_reset();
        #3;
        check("rst_state", 32'(state), 32'd0);
        check("rst_gclk_en", 32'(gclk_en), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        @(negedge mclk);
        rst_n = 1'b1;
        tick();
        tick();

        // Wake from OFF: WAKE for 4 edges, then ON, then the ack edge.
        req = 4'b0001;
        for (int e = 1; e <= WAKE_CYC; e++) begin
            tick();
            check("wake_state", 32'(state), 32'd1);
            check("wake_gclk_en", 32'(gclk_en), 32'd1);
            check("wake_ack", 32'(ack), 32'd0);
        end
        tick();
        check("on_entry_state", 32'(state), 32'd2);
        check("on_entry_ack", 32'(ack), 32'd0);
        tick();
        check("first_ack", 32'(ack), 32'd1);

        // Per-requester tracking.
        req = 4'b0101;
        tick();
        check("track_ack_0101", 32'(ack), 32'h5);
        req = 4'b0100;
        tick();
        check("track_ack_0100", 32'(ack), 32'h4);
        check("track_state", 32'(state), 32'd2);

        // Idle gate-off: DRAIN for IDLE_CYC edges, then OFF on the next edge.
        req = '0;
        for (int e = 1; e <= IDLE_CYC; e++) begin
            tick();
            check("drain_state", 32'(state), 32'd3);
            check("drain_gclk_en", 32'(gclk_en), 32'd1);
        end
        tick();
        check("gateoff_state", 32'(state), 32'd0);
        check("gateoff_gclk_en", 32'(gclk_en), 32'd0);
`ifdef CLK_GATE_STATS_EN
        check("gateoff_cnt", 32'(gate_cnt), 32'd1);
`endif

        // DRAIN rescue: the request returns on the same edge that the idle count expires.
        req = 4'b0001;
        for (int e = 0; e < WAKE_CYC + 2; e++) tick();
        check("rescue_pre_state", 32'(state), 32'd2);
        req = '0;
        for (int e = 1; e <= IDLE_CYC; e++) tick();
        check("rescue_last_drain", 32'(state), 32'd3);
        req = 4'b0010;
        tick();
        check("rescue_state", 32'(state), 32'd2);
        check("rescue_gclk_en", 32'(gclk_en), 32'd1);
        check("rescue_ack0", 32'(ack), 32'd0);
        tick();
        check("rescue_ack", 32'(ack), 32'h2);
`ifdef CLK_GATE_STATS_EN
        check("rescue_cnt", 32'(gate_cnt), 32'd1);
`endif

        // force_on: return to OFF, then hold ON without acks.
        req = '0;
        for (int e = 0; e < IDLE_CYC + 1; e++) tick();
        check("pre_force_state", 32'(state), 32'd0);
        force_on = 1'b1;
        for (int e = 0; e < WAKE_CYC + 1; e++) tick();
        for (int e = 0; e < 20; e++) begin
            tick();
            check("force_hold_state", 32'(state), 32'd2);
            check("force_hold_ack", 32'(ack), 32'd0);
        end
        force_on = 1'b0;
        for (int e = 0; e < IDLE_CYC; e++) tick();
        check("force_drain_state", 32'(state), 32'd3);
        tick();
        check("force_off_state", 32'(state), 32'd0);

        // Apply an asynchronous reset while ON with two requesters active.
        req = 4'b0011;
        for (int e = 0; e < WAKE_CYC + 2; e++) tick();
        check("pre_reset_ack", 32'(ack), 32'h3);
        async_reset("mid_on_reset");
        tick();
        check("post_reset_state", 32'(state), 32'd1);

        // Randomized traffic with occasional resets.
        mode = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) mode = int'($urandom_range(0, 3));
            case (mode)
                0: begin
                    req      = '0;
                    force_on = 1'b0;
                end
                1: begin
                    req      = N_REQ'($urandom);
                    force_on = 1'b0;
                end
                2: begin
                    if ($urandom_range(0, 3) == 0) req = N_REQ'($urandom);
                    force_on = 1'b0;
                end
                default: begin
                    req      = ($urandom_range(0, 1) == 0) ? '0 : N_REQ'($urandom);
                    force_on = 1'b1;
                end
            endcase
            if ($urandom_range(0, 299) == 0) async_reset("rand_reset");
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Sequences enable of the shared clock gating buffer (mclk in, gated bclk out) between N requesters.
- Wakes the buffer on demand, waits a settle period, grants per-requester acks, and gates it off after an idle timeout.
- Sits in the mclk domain beside the clock buffer. Drives its enable pin only; the gating cell itself is external.

Parameters:
N_REQ, 4, number of requesters (1..16)
WAKE_CYC, 4, settle cycles between enable assertion and ON (>=1)
IDLE_CYC, 8, idle cycles in DRAIN before gating off (>=1)

Ports:
mclk  input  1  master clock; all logic on posedge
rst_n  input  1  reset; one clock, asynchronous active-low reset (mclk, rst_n)
req  input  N_REQ  per-requester clock request, level, synchronous to mclk
force_on  input  1  debug override; keeps buffer enabled while high
gclk_en  output  1  registered enable to clock gating buffer
ack  output  N_REQ  registered per-requester grant; bclk valid while set
state  output  2  current FSM state (OFF=0, WAKE=1, ON=2, DRAIN=3)

Behaviour:
- Reset (async, rst_n low): state=OFF, gclk_en=0, ack=0, counter=0. Takes effect immediately, including mid-WAKE/ON/DRAIN. Operation resumes from OFF on the first edge after rst_n rises.
- Counter: width clog2(max(WAKE_CYC,IDLE_CYC))+1, unsigned, down-counting, never wraps.
- any = |req | force_on.
- OFF: gclk_en=0, ack=0. If any: go to WAKE, set gclk_en=1, load counter with WAKE_CYC-1.
- WAKE: gclk_en=1, ack=0. Decrement each cycle. At counter==0, go to ON.
  - No abort: if any drops during WAKE, WAKE still completes to ON, then proceeds to DRAIN.
- ON: gclk_en=1; ack <= req each cycle, so each ack bit follows its req with 1-cycle latency.
  - If !any: go to DRAIN, load counter with IDLE_CYC-1, ack <= 0.
  - force_on alone holds ON with ack=0.
- DRAIN: gclk_en=1, ack=0.
  - If any: go to ON. Counter is discarded; ack follows req from the next cycle.
  - Else if counter==0: go to OFF, gclk_en <= 0.
  - Else decrement.
  - A req arriving on the same edge as counter==0 wins: go to ON, not OFF.
- Latency, req sampled high in OFF at edge 0:
  - WAKE occupies edges 1..WAKE_CYC.
  - ON entered at edge WAKE_CYC+1.
  - ack high after edge WAKE_CYC+2.
- Gate-off latency: last req low sampled in ON at edge 0 -> DRAIN for IDLE_CYC cycles -> gclk_en low after edge IDLE_CYC+1.
- gclk_en changes only on posedge mclk; never toggles within a cycle.
- All outputs driven directly from flops.

Optional Feature:
- Macro: CLK_GATE_STATS_EN.
- Defined: adds output gate_cnt [15:0]. Increments on every DRAIN->OFF transition and saturates at 16'hFFFF. Reset to 0 by rst_n.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: rst_n low while in ON with req=4'b0011 -> gclk_en=0, ack=0, state=0 immediately, before the next mclk edge.
- Wake: defaults, req=4'b0001 sampled at edge 0 from OFF -> state=1 edges 1..4, state=2 at edge 5, ack=4'b0001 after edge 6, gclk_en=1 from edge 1.
- Per-requester tracking in ON: req 0001->0101->0100 on consecutive edges -> ack follows, delayed by 1 cycle; state stays 2.
- Idle gate-off: all req drop in ON at edge 0 -> state=3 for 8 cycles, gclk_en=0 and state=0 after edge 9; with CLK_GATE_STATS_EN, gate_cnt increments 0->1.
- DRAIN rescue: req reasserted on the edge DRAIN counter hits 0 -> state=2, gclk_en stays 1, ack follows req next cycle, gate_cnt unchanged.
- force_on: req=0, force_on=1 from OFF -> WAKE then ON held indefinitely with ack=0; force_on drop -> DRAIN -> OFF after 8 idle cycles.
